// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the two-core FPU arbiter.
package fpu_arb_pkg;

   localparam int FPU_OP_W            = 5;
   localparam int XLEN                = 32;
   localparam int TIMEOUT_CYC_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Two-input round-robin arbiter: combinational grant, registered last-winner pointer.
module fpu_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       update_id,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   // Holds the core granted most recently; resetting to 1 hands core 0 priority.
   logic last_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_id <= 1'b1;
      end else if (update) begin
         last_id <= update_id;
      end
   end

   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      if (req == 2'b11) begin
         gnt_id = ~last_id;
         gnt    = last_id ? 2'b01 : 2'b10;
      end else if (req[0]) begin
         gnt_id = 1'b0;
         gnt    = 2'b01;
      end else if (req[1]) begin
         gnt_id = 1'b1;
         gnt    = 2'b10;
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU between two cores: round-robin pick, issue, wait with timeout, respond.
module fpu_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                in_Clk,
   input  logic                in_Rst,
   input  logic [1:0]          in_req,
   input  logic [FPU_OP_W-1:0] in_op0,
   input  logic [FPU_OP_W-1:0] in_op1,
   input  logic [XLEN-1:0]     in_rs1_0,
   input  logic [XLEN-1:0]     in_rs2_0,
   input  logic [XLEN-1:0]     in_int_0,
   input  logic [XLEN-1:0]     in_rs1_1,
   input  logic [XLEN-1:0]     in_rs2_1,
   input  logic [XLEN-1:0]     in_int_1,
   output logic [1:0]          out_gnt,
   output logic [1:0]          out_done,
   output logic [XLEN-1:0]     out_result,
   output logic                out_zero,
   output logic                out_err,
   output logic                out_busy,
   output logic                out_fpu_start,
   output logic [FPU_OP_W-1:0] out_fpu_op,
   output logic [XLEN-1:0]     out_fpu_rs1,
   output logic [XLEN-1:0]     out_fpu_rs2,
   output logic [XLEN-1:0]     out_fpu_int,
   input  logic [XLEN-1:0]     in_fpu_data,
   input  logic                in_fpu_stall
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   arb_state_t          state;
   arb_state_t          state_next;
   logic                winner_q;
   logic [FPU_OP_W-1:0] op_q;
   logic [XLEN-1:0]     rs1_q;
   logic [XLEN-1:0]     rs2_q;
   logic [XLEN-1:0]     int_q;
   logic [XLEN-1:0]     result_q;
   logic                err_q;
   logic [7:0]          wait_cnt;
   logic [1:0]          block_q;
   logic [1:0]          eligible;
   logic [1:0]          rr_gnt;
   logic                rr_id;
   logic                timeout_hit;

   // The core just served sits out exactly one IDLE cycle so the other core gets a look-in.
   assign eligible    = in_req & ~block_q;
   assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

   fpu_rr_arbiter u_rr (
      .clk       (in_Clk),
      .rst       (in_Rst),
      .req       (eligible),
      .update    (state == ST_RESP),
      .update_id (winner_q),
      .gnt       (rr_gnt),
      .gnt_id    (rr_id)
   );

   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      out_gnt       = 2'b00;
      out_done      = 2'b00;
      out_result    = '0;
      out_zero      = 1'b0;
      out_err       = 1'b0;
      out_busy      = (state != ST_IDLE);
      out_fpu_start = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (|rr_gnt) state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            out_gnt       = winner_q ? 2'b10 : 2'b01;
            out_fpu_start = 1'b1;
            state_next    = ST_WAIT;
         end
         ST_WAIT: begin
            if (!in_fpu_stall || timeout_hit) state_next = ST_RESP;
         end
         ST_RESP: begin
            out_done   = winner_q ? 2'b10 : 2'b01;
            out_result = result_q;
            out_zero   = (result_q == '0);
            out_err    = err_q;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign out_fpu_op  = op_q;
   assign out_fpu_rs1 = rs1_q;
   assign out_fpu_rs2 = rs2_q;
   assign out_fpu_int = int_q;

   // Payload is captured on the winning edge so later request/operand changes cannot leak in.
   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         winner_q <= 1'b0;
         op_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         int_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
         block_q  <= 2'b00;
      end else begin
         block_q <= 2'b00;
         unique case (state)
            ST_IDLE: begin
               if (|rr_gnt) begin
                  winner_q <= rr_id;
                  op_q     <= rr_id ? in_op1   : in_op0;
                  rs1_q    <= rr_id ? in_rs1_1 : in_rs1_0;
                  rs2_q    <= rr_id ? in_rs2_1 : in_rs2_0;
                  int_q    <= rr_id ? in_int_1 : in_int_0;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               if (!in_fpu_stall) begin
                  result_q <= in_fpu_data;
                  err_q    <= 1'b0;
               end else if (timeout_hit) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               block_q <= winner_q ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
   end

endmodule
